// File: rtl/glb_stream_buffer_if.sv
// Bus bundle for glb_stream_buffer: host write port, burst control, stream output.
// When GLB_STALL_CNT_EN is defined, the bundle also carries the 16-bit stall_cnt.
interface glb_stream_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_COL    = 8,
    parameter int NUM_CH     = 2
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int XID_W = $clog2(NUM_COL) + 1;

    // Host write port
    logic                  wr_valid;
    logic                  wr_ready;
    logic [CH_W-1:0]       wr_ch;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Burst control
    logic                  start;
    logic [CH_W-1:0]       rd_ch;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [ADDR_WIDTH-1:0] rd_len;
    logic [7:0]            kernel_size;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    // Stream output
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [XID_W-1:0]      out_x_id;
    logic                  out_last;

`ifdef GLB_STALL_CNT_EN
    logic [15:0]           stall_cnt;

    modport slave (
        input  wr_valid, wr_ch, wr_addr, wr_data,
        input  start, rd_ch, rd_base, rd_len, kernel_size, out_ready,
        output wr_ready, busy, done, cfg_err,
        output out_valid, out_data, out_x_id, out_last, stall_cnt
    );

    modport master (
        output wr_valid, wr_ch, wr_addr, wr_data,
        output start, rd_ch, rd_base, rd_len, kernel_size, out_ready,
        input  wr_ready, busy, done, cfg_err,
        input  out_valid, out_data, out_x_id, out_last, stall_cnt
    );
`else
    modport slave (
        input  wr_valid, wr_ch, wr_addr, wr_data,
        input  start, rd_ch, rd_base, rd_len, kernel_size, out_ready,
        output wr_ready, busy, done, cfg_err,
        output out_valid, out_data, out_x_id, out_last
    );

    modport master (
        output wr_valid, wr_ch, wr_addr, wr_data,
        output start, rd_ch, rd_base, rd_len, kernel_size, out_ready,
        input  wr_ready, busy, done, cfg_err,
        input  out_valid, out_data, out_x_id, out_last
    );
`endif
endinterface

// File: rtl/glb_stream_buffer.sv
// glb_stream_buffer: multi-bank global buffer feeding the PE array X-bus.
// Host writes land in NUM_CH banks; a start request streams one bank out as a
// valid/ready burst tagged with a column id cycling 1..kernel_size.
// Optional feature macro: GLB_STALL_CNT_EN (adds the saturating stall_cnt output).
module glb_stream_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_COL    = 8,
    parameter int NUM_CH     = 2
) (
    input  logic               bus_clk,
    input  logic               rst,
    glb_stream_buffer_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int XID_W = $clog2(NUM_COL) + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Control FSM state and registered status outputs
    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cfg_err;

    // Burst configuration captured at start
    logic [CH_W-1:0]       r_ch;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [XID_W-1:0]      r_ks;

    // Burst progress
    logic [ADDR_WIDTH-1:0] r_issue_cnt;
    logic [ADDR_WIDTH-1:0] r_out_cnt;
    logic [XID_W-1:0]      r_xid;

    // Read pipeline: RAM output register and its valid
    logic [DATA_WIDTH-1:0] r_rd_data_p1;
    logic                  r_vld_p1;

    // Bank storage
    logic [DATA_WIDTH-1:0] r_mem [NUM_CH][DEPTH];

    // 2-entry skid FIFO behind the read register
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_fifo_cnt;

    logic                  w_ks_ok;
    logic                  w_start_ok;
    logic                  w_wr_fire;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_out_valid;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // Column tag advance with wrap back to 1 after kernel_size.
    function automatic logic [XID_W-1:0] next_xid(input logic [XID_W-1:0] cur,
                                                  input logic [XID_W-1:0] ks);
        return (cur >= ks) ? XID_W'(1) : cur + XID_W'(1);
    endfunction

    assign w_ks_ok    = (bus.kernel_size != 8'd0) && (bus.kernel_size <= 8'(NUM_COL));
    assign w_start_ok = (r_state == S_IDLE) && bus.start && w_ks_ok;

    // The bank being streamed is locked against host writes for the whole burst,
    // which also rules out a same-cycle write/read of one address.
    assign bus.wr_ready = !(r_busy && (bus.wr_ch == r_ch));
    assign w_wr_fire    = bus.wr_valid && bus.wr_ready;

    // Keep FIFO occupancy plus the in-flight read below 2 so nothing overflows.
    assign w_rd_addr = r_base + r_issue_cnt;
    assign w_issue   = (r_state == S_RUN) && (r_issue_cnt != r_len) &&
                       ((r_fifo_cnt + {1'b0, r_vld_p1}) < 2'd2);

    // Head of stream: FIFO entry if any, otherwise the fresh RAM output (bypass).
    assign w_out_valid = (r_fifo_cnt != 2'd0) || r_vld_p1;
    assign w_head      = (r_fifo_cnt == 2'd0) ? r_rd_data_p1 : r_fifo_data[r_rptr];
    assign w_hs        = w_out_valid && bus.out_ready;
    assign w_last      = (r_out_cnt == (r_len - ADDR_WIDTH'(1)));

    // RAM word enters the FIFO unless it is consumed straight from the bypass.
    assign w_push = r_vld_p1 && !((r_fifo_cnt == 2'd0) && bus.out_ready);
    assign w_pop  = w_hs && (r_fifo_cnt != 2'd0);

    // Data fields are forced to zero whenever no word is presented.
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_head : '0;
    assign bus.out_x_id  = w_out_valid ? r_xid : '0;
    assign bus.out_last  = w_out_valid && w_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfg_err;

    // Control FSM: accepts bursts, detects the final handshake, pulses done/cfg_err.
    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_ch      <= '0;
            r_base    <= '0;
            r_len     <= '0;
            r_ks      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_ks_ok) begin
                            r_ch   <= bus.rd_ch;
                            r_base <= bus.rd_base;
                            r_len  <= bus.rd_len;
                            r_ks   <= bus.kernel_size[XID_W-1:0];
                            if (bus.rd_len == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs && w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Burst bookkeeping: read issue count, in-flight flag, FIFO pointers, tag.
    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_xid       <= XID_W'(1);
            r_vld_p1    <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else if (w_start_ok) begin
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_xid       <= XID_W'(1);
            r_vld_p1    <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            r_vld_p1 <= w_issue;
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + ADDR_WIDTH'(1);
            end
            if (w_hs) begin
                r_out_cnt <= r_out_cnt + ADDR_WIDTH'(1);
                r_xid     <= next_xid(r_xid, r_ks);
            end
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // ---- stage p0 -> p1: bank write port and synchronous stream read ----
    // Bank storage: host writes and the 1-cycle-latency stream read.
    always_ff @(posedge bus_clk) begin
        if (w_wr_fire) begin
            r_mem[bus.wr_ch][bus.wr_addr] <= bus.wr_data;
        end
        if (w_issue) begin
            r_rd_data_p1 <= r_mem[r_ch][w_rd_addr];
        end
    end

    // ---- stage p1 -> skid FIFO ----
    // Skid FIFO storage: parks RAM words the consumer has not yet taken.
    always_ff @(posedge bus_clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= r_rd_data_p1;
        end
    end

`ifdef GLB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating +1 for the stall counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stall counter: busy cycles where a valid word waits on the consumer.
    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if (r_busy && w_out_valid && !bus.out_ready) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    // Stall counter not built in this configuration.
`endif
endmodule

// File: tb/tb_glb_stream_buffer.sv
// Directed testbench for glb_stream_buffer (default parameters).
module tb_glb_stream_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glb_stream_buffer_if bus ();
    glb_stream_buffer dut (.bus_clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] got_data [64];
    logic [3:0]  got_xid  [64];
    logic        got_last [64];
    int n_got, done_cyc, first_vld_cyc, n_unstable, n_stall;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input logic ch, input logic [9:0] addr, input logic [15:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_ch    = ch;
        bus.wr_addr  = addr;
        bus.wr_data  = data;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    // Start a burst and record every handshaken word until done (bounded).
    // mode 0: out_ready high; mode 1: out_ready high only on odd cycles.
    task automatic run_burst(input logic ch, input logic [9:0] base, input logic [9:0] len,
                             input logic [7:0] ks, input int mode);
        logic        stalled;
        logic [15:0] pd;
        logic [3:0]  px;
        logic        pl;
        bus.rd_ch = ch;
        bus.rd_base = base;
        bus.rd_len = len;
        bus.kernel_size = ks;
        bus.start = 1'b1;
        n_got = 0; done_cyc = -1; first_vld_cyc = -1; n_unstable = 0; n_stall = 0;
        stalled = 1'b0; pd = '0; px = '0; pl = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== pd ||
                            bus.out_x_id !== px || bus.out_last !== pl))
                n_unstable++;
            if (bus.out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                if (n_got < 64) begin
                    got_data[n_got] = bus.out_data;
                    got_xid[n_got]  = bus.out_x_id;
                    got_last[n_got] = bus.out_last;
                end
                n_got++;
            end
            stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
            if (stalled) begin
                n_stall++;
                pd = bus.out_data; px = bus.out_x_id; pl = bus.out_last;
            end
            tick();
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %0b want 1", bus.wr_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0 || bus.cfg_err !== 1'b0) $display("FAIL reset_pulses got done=%0b cfg_err=%0b want 0", bus.done, bus.cfg_err); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_x_id !== 4'h0 || bus.out_last !== 1'b0)
            $display("FAIL reset_stream got v=%0b d=%h x=%0d l=%0b want zeros", bus.out_valid, bus.out_data, bus.out_x_id, bus.out_last); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_burst();
        for (int i = 0; i < 10; i++) hwrite(1'b0, 10'(i), 16'h100 + 16'(i));
        run_burst(1'b0, 10'd0, 10'd10, 8'd3, 0);
        n_checks++; if (n_got != 10) $display("FAIL basic_count got %0d want 10", n_got); else n_pass++;
        n_checks++; if (first_vld_cyc != 2) $display("FAIL basic_first_valid got cycle %0d want 2", first_vld_cyc); else n_pass++;
        n_checks++; if (done_cyc != 12) $display("FAIL basic_done_cycle got %0d want 12", done_cyc); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_at_done got %0b want 0", bus.busy); else n_pass++;
        for (int i = 0; i < 10 && i < n_got; i++) begin
            n_checks++; if (got_data[i] !== 16'h100 + 16'(i)) $display("FAIL basic_data[%0d] got %h want %h", i, got_data[i], 16'h100 + 16'(i)); else n_pass++;
            n_checks++; if (got_xid[i] !== 4'((i % 3) + 1)) $display("FAIL basic_xid[%0d] got %0d want %0d", i, got_xid[i], (i % 3) + 1); else n_pass++;
            n_checks++; if (got_last[i] !== (i == 9)) $display("FAIL basic_last[%0d] got %0b want %0b", i, got_last[i], (i == 9)); else n_pass++;
        end
        tick();
    endtask

    task automatic test_backpressure();
        run_burst(1'b0, 10'd0, 10'd10, 8'd3, 1);
        n_checks++; if (n_got != 10) $display("FAIL bp_count got %0d want 10", n_got); else n_pass++;
        n_checks++; if (done_cyc < 0) $display("FAIL bp_done_seen got none want pulse"); else n_pass++;
        n_checks++; if (n_unstable != 0) $display("FAIL bp_stable got %0d unstable cycles want 0", n_unstable); else n_pass++;
        for (int i = 0; i < 10 && i < n_got; i++) begin
            n_checks++; if (got_data[i] !== 16'h100 + 16'(i) || got_xid[i] !== 4'((i % 3) + 1) || got_last[i] !== (i == 9))
                $display("FAIL bp_word[%0d] got d=%h x=%0d l=%0b want d=%h x=%0d l=%0b", i, got_data[i], got_xid[i], got_last[i],
                         16'h100 + 16'(i), (i % 3) + 1, (i == 9)); else n_pass++;
        end
`ifdef GLB_STALL_CNT_EN
        n_checks++; if (bus.stall_cnt !== 16'(n_stall)) $display("FAIL bp_stall_cnt got %0d want %0d", bus.stall_cnt, n_stall); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_wrap();
        hwrite(1'b0, 10'h3FE, 16'h05FE);
        hwrite(1'b0, 10'h3FF, 16'h05FF);
        run_burst(1'b0, 10'h3FE, 10'd4, 8'd8, 0);
        n_checks++; if (n_got != 4) $display("FAIL wrap_count got %0d want 4", n_got); else n_pass++;
        n_checks++; if (done_cyc != 6) $display("FAIL wrap_done_cycle got %0d want 6", done_cyc); else n_pass++;
        n_checks++; if (n_got >= 4 && (got_data[0] !== 16'h05FE || got_data[1] !== 16'h05FF || got_data[2] !== 16'h0100 || got_data[3] !== 16'h0101))
            $display("FAIL wrap_data got %h %h %h %h want 05fe 05ff 0100 0101", got_data[0], got_data[1], got_data[2], got_data[3]); else n_pass++;
        n_checks++; if (n_got >= 4 && (got_xid[0] !== 4'd1 || got_xid[3] !== 4'd4 || got_last[3] !== 1'b1 || got_last[2] !== 1'b0))
            $display("FAIL wrap_tags got x0=%0d x3=%0d l2=%0b l3=%0b want 1 4 0 1", got_xid[0], got_xid[3], got_last[2], got_last[3]); else n_pass++;
        tick();
    endtask

    task automatic test_wr_block();
        int got;
        bit seen_done;
        bus.out_ready = 1'b0;
        bus.rd_ch = 1'b0; bus.rd_base = 10'd0; bus.rd_len = 10'd10; bus.kernel_size = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL blk_busy got %0b want 1", bus.busy); else n_pass++;
        bus.wr_valid = 1'b1; bus.wr_ch = 1'b0; bus.wr_addr = 10'd0; bus.wr_data = 16'hDEAD;
        #1;
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL blk_same_bank got wr_ready=%0b want 0", bus.wr_ready); else n_pass++;
        tick();
        bus.wr_ch = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 16'hBEEF;
        #1;
        n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL blk_other_bank got wr_ready=%0b want 1", bus.wr_ready); else n_pass++;
        tick();
        bus.wr_valid = 1'b0;
        bus.kernel_size = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.cfg_err !== 1'b0) $display("FAIL blk_start_ignored got cfg_err=%0b want 0", bus.cfg_err); else n_pass++;
        bus.out_ready = 1'b1;
        got = 0; seen_done = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.done === 1'b1) begin seen_done = 1; break; end
            if (bus.out_valid === 1'b1) got++;
            tick();
        end
        n_checks++; if (!seen_done || got != 10) $display("FAIL blk_drain got done=%0b words=%0d want 1 10", seen_done, got); else n_pass++;
        tick();
        run_burst(1'b1, 10'd5, 10'd1, 8'd1, 0);
        n_checks++; if (n_got != 1 || got_data[0] !== 16'hBEEF || got_xid[0] !== 4'd1 || got_last[0] !== 1'b1)
            $display("FAIL blk_ch1_read got n=%0d d=%h x=%0d l=%0b want 1 beef 1 1", n_got, got_data[0], got_xid[0], got_last[0]); else n_pass++;
        tick();
        run_burst(1'b0, 10'd0, 10'd1, 8'd1, 0);
        n_checks++; if (n_got != 1 || got_data[0] !== 16'h0100)
            $display("FAIL blk_ch0_unchanged got n=%0d d=%h want 1 0100", n_got, got_data[0]); else n_pass++;
        tick();
    endtask

    task automatic test_cfg_err();
        logic [7:0] bad [2];
        bad[0] = 8'd0;
        bad[1] = 8'd9;
        for (int k = 0; k < 2; k++) begin
            bus.rd_ch = 1'b0; bus.rd_base = 10'd0; bus.rd_len = 10'd4; bus.kernel_size = bad[k];
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            n_checks++; if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0)
                $display("FAIL cfg_err_ks%0d got cfg_err=%0b busy=%0b want 1 0", bad[k], bus.cfg_err, bus.busy); else n_pass++;
            tick();
            n_checks++; if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
                $display("FAIL cfg_err_pulse_ks%0d got cfg_err=%0b busy=%0b v=%0b want 0 0 0", bad[k], bus.cfg_err, bus.busy, bus.out_valid); else n_pass++;
        end
    endtask

    task automatic test_len0();
        run_burst(1'b0, 10'd0, 10'd0, 8'd2, 0);
        n_checks++; if (done_cyc != 1) $display("FAIL len0_done got cycle %0d want 1", done_cyc); else n_pass++;
        n_checks++; if (first_vld_cyc != -1 || bus.out_valid !== 1'b0) $display("FAIL len0_no_valid got first valid cycle %0d want none", first_vld_cyc); else n_pass++;
        tick();
        n_checks++; if (bus.done !== 1'b0) $display("FAIL len0_pulse_width got done=%0b want 0", bus.done); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        bit done_seen;
        bus.out_ready = 1'b1;
        bus.rd_ch = 1'b0; bus.rd_base = 10'd0; bus.rd_len = 10'd10; bus.kernel_size = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 16'h0 || bus.out_x_id !== 4'h0 || bus.wr_ready !== 1'b1)
            $display("FAIL rst_mid_outputs got v=%0b busy=%0b d=%h x=%0d wr_ready=%0b want 0 0 0 0 1",
                     bus.out_valid, bus.busy, bus.out_data, bus.out_x_id, bus.wr_ready); else n_pass++;
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.done === 1'b1) done_seen = 1;
        end
        n_checks++; if (done_seen) $display("FAIL rst_mid_no_done got done pulse want none"); else n_pass++;
        run_burst(1'b0, 10'd2, 10'd3, 8'd2, 0);
        n_checks++; if (n_got != 3 || done_cyc != 5) $display("FAIL rst_new_burst got n=%0d done_cyc=%0d want 3 5", n_got, done_cyc); else n_pass++;
        n_checks++; if (n_got >= 3 && (got_data[0] !== 16'h0102 || got_data[1] !== 16'h0103 || got_data[2] !== 16'h0104))
            $display("FAIL rst_new_data got %h %h %h want 0102 0103 0104", got_data[0], got_data[1], got_data[2]); else n_pass++;
        n_checks++; if (n_got >= 3 && (got_xid[0] !== 4'd1 || got_xid[1] !== 4'd2 || got_xid[2] !== 4'd1 || got_last[2] !== 1'b1))
            $display("FAIL rst_new_tags got %0d %0d %0d last=%0b want 1 2 1 1", got_xid[0], got_xid[1], got_xid[2], got_last[2]); else n_pass++;
        tick();
    endtask

    initial begin
        bus.wr_valid = 1'b0; bus.wr_ch = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.rd_ch = '0; bus.rd_base = '0; bus.rd_len = '0;
        bus.kernel_size = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_wrap();
        test_wr_block();
        test_cfg_err();
        test_len0();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
